// File: rtl/msk_clyde_rnd_sched.sv
// msk_clyde_rnd_sched
// Randomness scheduler and stall controller for a masked Clyde core.
// Each of NCH channels counts the enabled PRNG cycles spent refilling its
// word; the core is only enabled when every channel it asks for holds a
// full word. A small IDLE/LAUNCH/RUN machine handles the start handshake
// and a saturating counter records RUN cycles lost to missing randomness.

module msk_clyde_rnd_sched #(
    parameter int unsigned NCH              = 2,
    parameter int unsigned RND_RATE_DIVIDER = 1,
    parameter int unsigned CNT_W            = 16
) (
    input  logic             clk,
    input  logic             pre_syn_rst_n,
    input  logic             pre_enable_glob,
    input  logic             pre_data_in_valid,
    input  logic             core_in_process,
    input  logic [NCH-1:0]   need_rnd,
    output logic             enable_core,
    output logic [NCH-1:0]   enable_prng,
    output logic [NCH-1:0]   rnd_valid,
    output logic             ready_start_run,
    output logic             data_in_valid,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned FW = $clog2(RND_RATE_DIVIDER + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(RND_RATE_DIVIDER);
    localparam logic [FW-1:0]    FILL_ONE  = FW'(1);
    localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [FW-1:0]    fill_r [NCH];
    logic [CNT_W-1:0] stall_r;

    logic             active_s;
    logic [NCH-1:0]   valid_s;
    logic             ok_s;
    logic             ready_s;
    logic             dvalid_s;
    logic             en_core_s;
    logic [NCH-1:0]   consume_s;
    logic [NCH-1:0]   prng_s;

    // Everything is frozen while in reset or while the global enable is low.
    assign active_s = pre_syn_rst_n & pre_enable_glob;

    // A channel is valid once its fill counter reaches the refill length.
    always_comb begin
        valid_s = '0;
        for (int i = 0; i < NCH; i++) begin
            valid_s[i] = (fill_r[i] == FILL_FULL);
        end
    end

    // Only channels the core is asking for can hold it back.
    assign ok_s = &(~need_rnd | valid_s);

    // Output decode of the start/run machine.
    always_comb begin
        ready_s   = 1'b0;
        dvalid_s  = 1'b0;
        en_core_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready_s   = active_s & (&valid_s);
                dvalid_s  = ready_s & pre_data_in_valid;
                en_core_s = dvalid_s;
            end
            ST_LAUNCH: begin
                en_core_s = active_s;
            end
            ST_RUN: begin
                en_core_s = active_s & ok_s;
            end
            default: begin
                ready_s   = 1'b0;
                dvalid_s  = 1'b0;
                en_core_s = 1'b0;
            end
        endcase
    end

    // A consumed word is replaced starting in the same cycle, so a PRNG
    // runs whenever its word is incomplete or being taken.
    assign consume_s = {NCH{en_core_s}} & need_rnd;
    assign prng_s    = {NCH{active_s}} & (~valid_s | consume_s);

    // Next-state logic of the start/run machine.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (dvalid_s) begin
                    state_nxt_s = ST_LAUNCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (active_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LAUNCH;
                end
            end
            ST_RUN: begin
                if (active_s && !core_in_process) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register of the start/run machine.
    always_ff @(posedge clk) begin
        if (!pre_syn_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Per-channel fill counters: restart at one chunk on consumption,
    // otherwise count enabled PRNG cycles up to a full word.
    always_ff @(posedge clk) begin
        if (!pre_syn_rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                fill_r[i] <= '0;
            end
        end else if (pre_enable_glob) begin
            for (int i = 0; i < NCH; i++) begin
                if (consume_s[i]) begin
                    fill_r[i] <= FILL_ONE;
                end else if (prng_s[i]) begin
                    fill_r[i] <= fill_r[i] + FILL_ONE;
                end else begin
                    fill_r[i] <= fill_r[i];
                end
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                fill_r[i] <= fill_r[i];
            end
        end
    end

    // Stall counter: cleared on each accepted start, counts RUN cycles
    // where the core wanted a word that was not ready, saturating.
    always_ff @(posedge clk) begin
        if (!pre_syn_rst_n) begin
            stall_r <= '0;
        end else if (dvalid_s) begin
            stall_r <= '0;
        end else if ((state_r == ST_RUN) && active_s && !ok_s && (stall_r != STALL_MAX)) begin
            stall_r <= stall_r + STALL_ONE;
        end else begin
            stall_r <= stall_r;
        end
    end

    // Outputs are forced low while reset is asserted, even combinational ones.
    assign enable_core     = en_core_s;
    assign enable_prng     = prng_s;
    assign rnd_valid       = valid_s & {NCH{pre_syn_rst_n}};
    assign ready_start_run = ready_s;
    assign data_in_valid   = dvalid_s;
    assign stall_cycles    = stall_r & {CNT_W{pre_syn_rst_n}};

endmodule

// File: tb/tb_msk_clyde_rnd_sched.sv
// Directed testbench for msk_clyde_rnd_sched.
// Instance A: NCH=2, RND_RATE_DIVIDER=4, CNT_W=4 (prefill, stalls, freeze,
// saturation, exit, mid-run reset). Instance B: NCH=2, RND_RATE_DIVIDER=1,
// CNT_W=16 (back-to-back consumption without stalls).

module tb_msk_clyde_rnd_sched;

    logic clk;
    int   checks;
    int   errors;

    logic        a_rst_n, a_glob, a_pdv, a_cip;
    logic [1:0]  a_need;
    logic        a_en, a_ready, a_dv;
    logic [1:0]  a_prng, a_rv;
    logic [3:0]  a_stall;

    logic        b_rst_n, b_glob, b_pdv, b_cip;
    logic [1:0]  b_need;
    logic        b_en, b_ready, b_dv;
    logic [1:0]  b_prng, b_rv;
    logic [15:0] b_stall;

    msk_clyde_rnd_sched #(.NCH(2), .RND_RATE_DIVIDER(4), .CNT_W(4)) u_a (
        .clk               (clk),
        .pre_syn_rst_n     (a_rst_n),
        .pre_enable_glob   (a_glob),
        .pre_data_in_valid (a_pdv),
        .core_in_process   (a_cip),
        .need_rnd          (a_need),
        .enable_core       (a_en),
        .enable_prng       (a_prng),
        .rnd_valid         (a_rv),
        .ready_start_run   (a_ready),
        .data_in_valid     (a_dv),
        .stall_cycles      (a_stall)
    );

    msk_clyde_rnd_sched #(.NCH(2), .RND_RATE_DIVIDER(1), .CNT_W(16)) u_b (
        .clk               (clk),
        .pre_syn_rst_n     (b_rst_n),
        .pre_enable_glob   (b_glob),
        .pre_data_in_valid (b_pdv),
        .core_in_process   (b_cip),
        .need_rnd          (b_need),
        .enable_core       (b_en),
        .enable_prng       (b_prng),
        .rnd_valid         (b_rv),
        .ready_start_run   (b_ready),
        .data_in_valid     (b_dv),
        .stall_cycles      (b_stall)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_glob = 1'b1; b_glob = 1'b1;
        #1;
        checks++;
        if ({a_en, a_prng, a_rv, a_ready, a_dv, a_stall} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outs_a: got %b required 0", {a_en, a_prng, a_rv, a_ready, a_dv, a_stall});
        end
        checks++;
        if ({b_en, b_prng, b_rv, b_ready, b_dv, b_stall} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outs_b: got %b required 0", {b_en, b_prng, b_rv, b_ready, b_dv, b_stall});
        end
        tick();
        tick();
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        #1;
        checks++;
        if ({a_rv, a_prng, a_ready} !== 5'b00110) begin
            errors++;
            $display("FAIL prefill_c0: got %b required 00110", {a_rv, a_prng, a_ready});
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (a_rv !== ((k == 4) ? 2'b11 : 2'b00) || a_ready !== (k == 4)) begin
                errors++;
                $display("FAIL prefill_c%0d: got rv=%b ready=%b required rv=%b ready=%b",
                         k, a_rv, a_ready, (k == 4) ? 2'b11 : 2'b00, (k == 4));
            end
            if (k == 1) begin
                checks++;
                if ({b_rv, b_ready} !== 3'b111) begin
                    errors++;
                    $display("FAIL prefill_div1: got %b required 111", {b_rv, b_ready});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        tick();
        b_need = 2'b11; b_pdv = 1'b1; b_cip = 1'b1;
        #1;
        checks++;
        if ({b_ready, b_dv, b_en} !== 3'b111) begin
            errors++;
            $display("FAIL b2b_start: got %b required 111", {b_ready, b_dv, b_en});
        end
        tick();
        b_pdv = 1'b0;
        #1;
        checks++;
        if ({b_en, b_dv, b_stall} !== {1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL b2b_launch: got en=%b dv=%b stall=%0d required en=1 dv=0 stall=0", b_en, b_dv, b_stall);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 5) b_cip = 1'b0;
            #1;
            checks++;
            if ({b_en, b_rv, b_dv} !== 4'b1110) begin
                errors++;
                $display("FAIL b2b_run%0d: got %b required 1110", k, {b_en, b_rv, b_dv});
            end
        end
        tick();
        b_need = 2'b00; b_cip = 1'b0;
        #1;
        checks++;
        if ({b_ready, b_rv, b_en} !== 4'b1110 || b_stall !== 16'd0) begin
            errors++;
            $display("FAIL b2b_idle: got ready/rv/en=%b stall=%0d required 1110 stall=0", {b_ready, b_rv, b_en}, b_stall);
        end
    endtask

    task automatic test_stall_duty();
        tick();
        a_pdv = 1'b1; a_need = 2'b00; a_cip = 1'b1;
        #1;
        checks++;
        if ({a_dv, a_en} !== 2'b11) begin
            errors++;
            $display("FAIL duty_start: got %b required 11", {a_dv, a_en});
        end
        tick();
        a_pdv = 1'b0;
        #1;
        checks++;
        if ({a_en, a_ready, a_stall} !== {1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL duty_launch: got %b required 100000", {a_en, a_ready, a_stall});
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            a_need = 2'b01;
            #1;
            checks++;
            if (a_en !== ((k % 4) == 0) || a_rv[1] !== 1'b1) begin
                errors++;
                $display("FAIL duty_r%0d: got en=%b rv1=%b required en=%b rv1=1", k + 1, a_en, a_rv[1], ((k % 4) == 0));
            end
            if (k == 4) begin
                checks++;
                if (a_stall !== 4'd3) begin
                    errors++;
                    $display("FAIL duty_stall_word: got %0d required 3", a_stall);
                end
            end
        end
        tick();
        #1;
        checks++;
        if (a_stall !== 4'd6 || a_en !== 1'b1) begin
            errors++;
            $display("FAIL duty_stall_r9: got stall=%0d en=%b required 6 1", a_stall, a_en);
        end
    endtask

    task automatic test_glob_freeze();
        tick();
        #1;
        tick();
        a_glob = 1'b0;
        #1;
        for (int f = 0; f < 5; f++) begin
            if (f != 0) begin
                tick();
                #1;
            end
            checks++;
            if ({a_en, a_prng, a_ready, a_dv} !== 5'd0 || a_stall !== 4'd7 || a_rv !== 2'b10) begin
                errors++;
                $display("FAIL freeze_%0d: got en/prng/rdy/dv=%b stall=%0d rv=%b required 00000 7 10",
                         f, {a_en, a_prng, a_ready, a_dv}, a_stall, a_rv);
            end
        end
        tick();
        a_glob = 1'b1;
        #1;
        checks++;
        if ({a_en, a_prng} !== 3'b001 || a_stall !== 4'd7) begin
            errors++;
            $display("FAIL resume_0: got en/prng=%b stall=%0d required 001 7", {a_en, a_prng}, a_stall);
        end
        tick();
        #1;
        checks++;
        if (a_en !== 1'b0 || a_stall !== 4'd8) begin
            errors++;
            $display("FAIL resume_1: got en=%b stall=%0d required 0 8", a_en, a_stall);
        end
        tick();
        #1;
        checks++;
        if (a_en !== 1'b1 || a_stall !== 4'd9) begin
            errors++;
            $display("FAIL resume_2: got en=%b stall=%0d required 1 9", a_en, a_stall);
        end
    endtask

    task automatic test_saturation();
        for (int k = 1; k <= 28; k++) begin
            tick();
            #1;
            if (k == 4) begin
                checks++;
                if (a_stall !== 4'd12) begin
                    errors++;
                    $display("FAIL sat_count: got %0d required 12", a_stall);
                end
            end
        end
        checks++;
        if (a_stall !== 4'd15 || a_en !== 1'b1) begin
            errors++;
            $display("FAIL sat_final: got stall=%0d en=%b required 15 1", a_stall, a_en);
        end
    endtask

    task automatic test_run_exit();
        a_pdv = 1'b1; a_need = 2'b00;
        #1;
        checks++;
        if ({a_dv, a_ready, a_en} !== 3'b001) begin
            errors++;
            $display("FAIL run_pdv_0: got %b required 001", {a_dv, a_ready, a_en});
        end
        tick();
        a_need = 2'b01; a_cip = 1'b0;
        #1;
        checks++;
        if ({a_dv, a_ready, a_en} !== 3'b001) begin
            errors++;
            $display("FAIL run_pdv_1: got %b required 001", {a_dv, a_ready, a_en});
        end
        tick();
        a_need = 2'b00; a_cip = 1'b1;
        #1;
        checks++;
        if ({a_rv, a_ready, a_dv, a_en, a_prng} !== 7'b1000001 || a_stall !== 4'd15) begin
            errors++;
            $display("FAIL exit_idle: got %b stall=%0d required 1000001 15", {a_rv, a_ready, a_dv, a_en, a_prng}, a_stall);
        end
        for (int k = 2; k <= 4; k++) begin
            tick();
            #1;
            checks++;
            if ({a_ready, a_dv} !== ((k == 4) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL refill_i%0d: got %b required %b", k, {a_ready, a_dv}, (k == 4) ? 2'b11 : 2'b00);
            end
        end
        tick();
        a_pdv = 1'b0; a_cip = 1'b0;
        #1;
        checks++;
        if (a_stall !== 4'd0 || a_en !== 1'b1) begin
            errors++;
            $display("FAIL restart_launch: got stall=%0d en=%b required 0 1", a_stall, a_en);
        end
        tick();
        #1;
        checks++;
        if ({a_ready, a_en} !== 2'b01) begin
            errors++;
            $display("FAIL launch_ignores_cip: got %b required 01", {a_ready, a_en});
        end
        a_cip = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        tick();
        a_need = 2'b01;
        #1;
        for (int k = 2; k <= 4; k++) begin
            tick();
            #1;
        end
        checks++;
        if (a_stall !== 4'd2 || a_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_s4: got stall=%0d en=%b required 2 0", a_stall, a_en);
        end
        tick();
        #1;
        checks++;
        if (a_stall !== 4'd3 || a_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_s5: got stall=%0d en=%b required 3 1", a_stall, a_en);
        end
        a_rst_n = 1'b0;
        #1;
        checks++;
        if ({a_en, a_prng, a_rv, a_ready, a_dv, a_stall} !== 11'd0) begin
            errors++;
            $display("FAIL mid_rst_outs: got %b required 0", {a_en, a_prng, a_rv, a_ready, a_dv, a_stall});
        end
        tick();
        a_rst_n = 1'b1; a_pdv = 1'b1;
        #1;
        checks++;
        if ({a_rv, a_en, a_ready, a_dv, a_prng} !== 7'b0000011 || a_stall !== 4'd0) begin
            errors++;
            $display("FAIL post_rst: got %b stall=%0d required 0000011 0", {a_rv, a_en, a_ready, a_dv, a_prng}, a_stall);
        end
        tick();
        a_pdv = 1'b0;
    endtask

    // Test sequence.
    initial begin
        checks = 0; errors = 0;
        clk = 1'b0;
        a_rst_n = 1'b0; a_glob = 1'b0; a_pdv = 1'b0; a_cip = 1'b0; a_need = 2'b00;
        b_rst_n = 1'b0; b_glob = 1'b0; b_pdv = 1'b0; b_cip = 1'b0; b_need = 2'b00;
        test_reset();
        test_back_to_back();
        test_stall_duty();
        test_glob_freeze();
        test_saturation();
        test_run_exit();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
